cordic_sincos: RTL and testbench
================================

CORDIC_SINCOS -- requirements
Module: cordic_sincos

Interface
REQ-001 SHALL have parameter M, default 32, giving the width of the phase input and of both outputs.
REQ-002 SHALL have parameter N, default 5, giving the iteration-counter width.
REQ-003 SHALL have parameter ITER, default 24, giving the number of CORDIC micro-rotations (1..2^N-1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: phase is valid.
REQ-007 SHALL have port phase, input, M bits, signed Q3.29 radians, nominal range [-pi, +pi], from the phase accumulator.
REQ-008 SHALL have port in_ready, output, 1 bit: high only in IDLE.
REQ-009 SHALL have port out_valid, output, 1 bit: high only in DONE.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have ports cos_out and sin_out, output, M bits each, signed Q2.30, registered.

Function
REQ-012 SHALL implement the FSM states IDLE, ROTATE and DONE.
REQ-013 IDLE SHALL move to ROTATE when in_valid is high (in_ready is high); phase is captured on that edge.
REQ-014 On capture, quadrant fold SHALL apply:
- phase > pi/2 (0x3243F6A9): z = phase - pi, neg = 1.
- phase < -pi/2: z = phase + pi, neg = 1.
- Otherwise: z = phase, neg = 0.
REQ-015 On capture, initial values SHALL be x = K = 0x26DD3B6A (0.6072529350 × 2^30) and y = 0.
REQ-016 ROTATE SHALL perform one micro-rotation per cycle for i = 0..ITER-1, driven by z's sign:
- d = +1 if z >= 0, else -1.
- x' = x - d·(y>>>i), y' = y + d·(x>>>i), z' = z - d·atan_i.
REQ-017 atan_i SHALL be a constant table of round(atan(2^-i) × 2^29), with atan_0 = 0x1921FB54.
REQ-018 x and y SHALL be held internally in M+2 bits with arithmetic shifts; truncation only, no rounding.
REQ-019 After the micro-rotation with i = ITER-1, the block SHALL enter DONE and register cos_out = neg ? -x : x and sin_out = neg ? -y : y, truncated to M bits.
REQ-020 Latency SHALL be exactly ITER+1 cycles from the capture edge to out_valid high.
REQ-021 DONE SHALL hold out_valid, cos_out and sin_out stable until out_ready is high, then return to IDLE on that edge.
REQ-022 There SHALL be no overlap: in_valid is ignored outside IDLE, and a new capture is possible one cycle after the DONE exit at the earliest.
REQ-023 out_ready SHALL be ignored outside DONE; in_valid and out_ready both high in DONE SHALL only exit DONE.
REQ-024 phase exactly ±pi/2 SHALL take the unfolded path; phase exactly ±pi SHALL fold to z = 0, neg = 1.

Reset
REQ-025 rst low SHALL immediately force state IDLE, counter 0, x, y, z, neg = 0, cos_out = sin_out = 0, out_valid = 0, in_ready = 1.
REQ-026 Reset asserted mid-ROTATE or in DONE SHALL discard the computation, with no output pulse after release.
REQ-027 After rst release, the first capture SHALL be possible on the first rising edge.

Configuration
REQ-028 Macro CORDIC_PHASE_WRAP_EN, when defined, SHALL pre-wrap the captured phase in M+1 bits before the fold:
- phase > pi: subtract 2pi.
- phase < -pi: add 2pi.
This absorbs accumulator overshoot up to 0x7FFFFFFF.
REQ-029 Without CORDIC_PHASE_WRAP_EN, no pre-wrap logic SHALL exist, and results for |phase| > pi are unspecified.

Verification
REQ-030 Test 1: phase = 0 -> after 25 cycles, cos_out = 0x40000000 and sin_out = 0, each within ±512 LSB.
REQ-031 Test 2: phase = 0x3243F6A9 (pi/2) -> cos_out ≈ 0 and sin_out ≈ 0x40000000, each within ±512 LSB.
REQ-032 Test 3: phase = 0xE6DE04AC (-pi/4) -> cos_out ≈ 0x2D413CCD and sin_out ≈ 0xD2BEC333, each within ±512; phase = 0x6487ED51 (pi) -> cos_out ≈ 0xC0000000, sin_out ≈ 0.
REQ-033 Test 4: hold out_ready low 10 cycles in DONE -> out_valid, cos_out and sin_out constant, in_ready low; in_valid pulses meanwhile are ignored.
REQ-034 Test 5: rst low at ROTATE cycle 7, released 2 cycles later -> all outputs 0, in_ready = 1, no out_valid until a new capture.
REQ-035 Test 6 (CORDIC_PHASE_WRAP_EN): phase = 0x7FFFFFFF (≈4.0 rad) -> cos_out ≈ -0.65364 × 2^30 and sin_out ≈ -0.75680 × 2^30, each within ±1024 LSB.

Source files
------------

// File: rtl/cordic_sincos.sv
// cordic_sincos: iterative CORDIC sine/cosine generator.
//
// Takes one phase word in Q3.29 radians (nominally [-pi, +pi]). The phase is
// folded into [-pi/2, +pi/2] with a sign flag. After that the block runs one
// micro-rotation per clock. The results are presented as registered Q2.30
// cos/sin values under a valid/ready handshake.
//
// Optional build macro: CORDIC_PHASE_WRAP_EN
//   When defined, the captured phase is first wrapped into [-pi, +pi] in M+1
//   bits. This absorbs phase-accumulator overshoot up to 0x7FFFFFFF.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous reset, active low
//   in_valid   phase is valid (captured when in_ready is high)
//   phase      signed Q3.29 phase, M bits
//   in_ready   high only while idle
//   out_valid  high only while a result is presented
//   out_ready  downstream accepts the result
//   cos_out    signed Q2.30 cosine, M bits, registered
//   sin_out    signed Q2.30 sine, M bits, registered
//
// state  | meaning
// IDLE   | waiting for a phase, in_ready high
// ROTATE | micro-rotations i = 0..ITER-1, then one cycle to register results
// DONE   | result held, out_valid high until out_ready
module cordic_sincos #(
  parameter int M    = 32,
  parameter int N    = 5,
  parameter int ITER = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [M-1:0] phase,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] cos_out,
  output logic [M-1:0] sin_out
);

  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_e;

  localparam logic signed [M-1:0] HALF_PI = M'(32'sh3243F6A9);
  localparam logic signed [M-1:0] PI_C    = M'(32'sh6487ED51);
  localparam logic signed [M-1:0] K_C     = M'(32'sh26DD3B6A);

  // round(atan(2^-i) * 2^29)
  localparam logic [31:0] ATAN_TAB [32] = '{
    32'h1921FB54, 32'h0ED63383, 32'h07D6DD7E, 32'h03FAB753,
    32'h01FF55BB, 32'h00FFEAAE, 32'h007FFD55, 32'h003FFFAB,
    32'h001FFFF5, 32'h000FFFFF, 32'h00080000, 32'h00040000,
    32'h00020000, 32'h00010000, 32'h00008000, 32'h00004000,
    32'h00002000, 32'h00001000, 32'h00000800, 32'h00000400,
    32'h00000200, 32'h00000100, 32'h00000080, 32'h00000040,
    32'h00000020, 32'h00000010, 32'h00000008, 32'h00000004,
    32'h00000002, 32'h00000001, 32'h00000000, 32'h00000000
  };

  state_e                state_q, state_d;
  logic [N-1:0]          cnt_q, cnt_d;
  logic signed [M+1:0]   x_q, x_d;
  logic signed [M+1:0]   y_q, y_d;
  logic signed [M-1:0]   z_q, z_d;
  logic                  neg_q, neg_d;
  logic [M-1:0]          cos_q, cos_d;
  logic [M-1:0]          sin_q, sin_d;

  logic signed [M-1:0]   ph_w;
  logic signed [M-1:0]   z_fold;
  logic                  neg_fold;
  logic signed [M+1:0]   x_sh, y_sh;
  logic signed [M-1:0]   atan_c;

`ifdef CORDIC_PHASE_WRAP_EN
  localparam logic signed [M:0] PI_W     = (M+1)'(33'sh0_6487ED51);
  localparam logic signed [M:0] TWO_PI_W = (M+1)'(33'sh0_C90FDAA2);
  logic signed [M:0] ph_ext;

  // One extra bit so that phase +/- 2pi cannot overflow before the fold.
  always_comb begin
    ph_ext = {phase[M-1], phase};
    if (ph_ext > PI_W) begin
      ph_ext = ph_ext - TWO_PI_W;
    end else if (ph_ext < -PI_W) begin
      ph_ext = ph_ext + TWO_PI_W;
    end
    ph_w = M'(ph_ext);
  end
`else
  assign ph_w = $signed(phase);
`endif

  // Exactly +/-pi/2 stays unfolded; exactly +/-pi folds to z = 0 with negation.
  always_comb begin
    z_fold   = ph_w;
    neg_fold = 1'b0;
    if (ph_w > HALF_PI) begin
      z_fold   = ph_w - PI_C;
      neg_fold = 1'b1;
    end else if (ph_w < -HALF_PI) begin
      z_fold   = ph_w + PI_C;
      neg_fold = 1'b1;
    end
  end

  assign x_sh   = x_q >>> cnt_q;
  assign y_sh   = y_q >>> cnt_q;
  assign atan_c = M'(ATAN_TAB[cnt_q]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    neg_d   = neg_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = ROTATE;
          cnt_d   = '0;
          x_d     = (M+2)'(K_C);
          y_d     = '0;
          z_d     = z_fold;
          neg_d   = neg_fold;
        end
      end
      ROTATE: begin
        // cnt_q == ITER is the extra cycle that registers the outputs,
        // which gives ITER+1 cycles from capture to out_valid.
        if (cnt_q == N'(ITER)) begin
          cos_d   = M'(neg_q ? -x_q : x_q);
          sin_d   = M'(neg_q ? -y_q : y_q);
          state_d = DONE;
        end else begin
          if (!z_q[M-1]) begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - atan_c;
          end else begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + atan_c;
          end
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      neg_q   <= 1'b0;
      cos_q   <= '0;
      sin_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      neg_q   <= neg_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign cos_out   = cos_q;
  assign sin_out   = sin_q;

endmodule

// File: tb/tb_cordic_sincos.sv
module tb_cordic_sincos;

  localparam int M    = 32;
  localparam int N    = 5;
  localparam int ITER = 24;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [M-1:0] phase;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] cos_out;
  logic [M-1:0] sin_out;

  cordic_sincos #(.M(M), .N(N), .ITER(ITER)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .phase     (phase),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cos_out   (cos_out),
    .sin_out   (sin_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string  tag;
    longint c;
    longint s;
    longint tol;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp, input longint tol);
    longint diff;
    diff = obs - exp;
    total++;
    if (diff > tol || diff < -tol) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic longint model_val(input logic [31:0] ph, input bit want_sin);
    real a;
    real v;
    a = $itor($signed(ph)) / 536870912.0;
    v = (want_sin ? $sin(a) : $cos(a)) * 1073741824.0;
    return longint'($rtoi(v >= 0.0 ? v + 0.5 : v - 0.5));
  endfunction

  // Scoreboard consumer: a result is compared on the cycle it is accepted.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_val("spurious_out", 1, 0, 0);
      end else begin
        mon_e = sb.pop_front();
        check_val({mon_e.tag, "_cos"}, longint'($signed(cos_out)), mon_e.c, mon_e.tol);
        check_val({mon_e.tag, "_sin"}, longint'($signed(sin_out)), mon_e.s, mon_e.tol);
      end
    end
  end

  task automatic send(input string tag, input logic [31:0] ph, input longint tol, input int hold);
    exp_t        e;
    int          n;
    int          chg;
    int          irdy;
    logic [31:0] c0;
    logic [31:0] s0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    e.tag = tag;
    e.c   = model_val(ph, 1'b0);
    e.s   = model_val(ph, 1'b1);
    e.tol = tol;
    sb.push_back(e);
    in_valid = 1'b1;
    phase    = ph;
    @(posedge clk); #1;
    in_valid = 1'b0;
    phase    = $urandom;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_val({tag, "_lat"}, n, ITER + 1, 0);
    if (hold > 0) begin
      c0   = cos_out;
      s0   = sin_out;
      chg  = 0;
      irdy = 0;
      for (int k = 0; k < hold; k++) begin
        in_valid = k[0];
        phase    = 32'h0;
        @(posedge clk); #1;
        if (!out_valid || cos_out != c0 || sin_out != s0) chg++;
        if (in_ready) irdy++;
      end
      check_val({tag, "_hold_chg"}, chg, 0, 0);
      check_val({tag, "_hold_irdy"}, irdy, 0, 0);
      in_valid = 1'b1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_val({tag, "_idle"}, in_ready, 1, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          pulses;
    longint      r;
    logic [31:0] ph;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    phase     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_irdy", in_ready, 1, 0);
    check_val("rst_oval", out_valid, 0, 0);
    check_val("rst_cos", cos_out, 0, 0);
    check_val("rst_sin", sin_out, 0, 0);
    rst = 1'b1;

    // First capture right after release, then the directed points.
    send("zero",    32'h00000000, 512, 0);
    send("pi2",     32'h3243F6A9, 512, 0);
    send("m_pi4",   32'hE6DE04AC, 512, 0);
    send("pi",      32'h6487ED51, 512, 0);
    send("m_pi2",   32'hCDBC0957, 512, 0);
    send("m_pi",    32'h9B7812AF, 512, 0);
    send("hold",    32'h10000000, 512, 10);

    for (int i = 0; i < 6; i++) begin
      r  = longint'($urandom_range(32'd3373259426, 32'd0)) - 64'sd1686629713;
      ph = 32'(r);
      send("rand", ph, 512, 0);
    end

    // Reset in the middle of a rotation discards the computation.
    in_valid = 1'b1;
    phase    = 32'h20000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_val("mid_rst_cos", cos_out, 0, 0);
    check_val("mid_rst_sin", sin_out, 0, 0);
    check_val("mid_rst_oval", out_valid, 0, 0);
    check_val("mid_rst_irdy", in_ready, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    check_val("rel_cos", cos_out, 0, 0);
    check_val("rel_sin", sin_out, 0, 0);
    out_ready = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    out_ready = 1'b0;
    check_val("no_pulse", pulses, 0, 0);
    check_val("rel_irdy", in_ready, 1, 0);

    send("after_rst", 32'h0C90FDAA, 512, 0);

`ifdef CORDIC_PHASE_WRAP_EN
    send("wrap", 32'h7FFFFFFF, 1024, 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check_val("sb_empty", sb.size(), 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
